// File: rtl/psdsquare.sv
// Sequential shift-add squarer: one multiplier bit per clock, start/busy/done handshake.
// Optional macro PSDSQUARE_EARLY_EN ends a run once the remaining multiplier bits are all zero.
module psdsquare #(
  parameter int MAXBITS = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [5:0]             NBITSIN,
  input  logic [MAXBITS-1:0]     rin,
  output logic [2*MAXBITS-1:0]   square,
  output logic                   busy,
  output logic                   done
);

  localparam int W = 2 * MAXBITS;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [W-1:0]       acc_r, acc_s, mcand_r, mcand_s, square_s, sum_s;
  logic [MAXBITS-1:0] mplier_r, mplier_s, mask_s, rin_masked_s;
  logic [5:0]         cnt_r, cnt_s, n_s;
  logic               busy_s, done_s, last_s;

  // Operand conditioning and the per-cycle partial-product add
  always_comb begin
    n_s          = (NBITSIN > 6'(MAXBITS)) ? 6'(MAXBITS) : NBITSIN;
    mask_s       = (n_s >= 6'(MAXBITS)) ? {MAXBITS{1'b1}}
                                        : ((MAXBITS'(1) << n_s) - MAXBITS'(1));
    rin_masked_s = rin & mask_s;
    sum_s        = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
`ifdef PSDSQUARE_EARLY_EN
    last_s       = (cnt_r == 6'd1) || ((mplier_r >> 1) == {MAXBITS{1'b0}});
`else
    last_s       = (cnt_r == 6'd1);
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    cnt_s    = cnt_r;
    square_s = square;
    busy_s   = busy;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          if (n_s != 6'd0) begin
            mplier_s = rin_masked_s;
            mcand_s  = {{MAXBITS{1'b0}}, rin_masked_s};
            acc_s    = {W{1'b0}};
            cnt_s    = n_s;
            busy_s   = 1'b1;
            state_s  = RUN;
          end else begin
            // Zero-width root: immediate result, no RUN phase
            square_s = {W{1'b0}};
            done_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        acc_s    = sum_s;
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        cnt_s    = cnt_r - 6'd1;
        if (last_s) begin
          square_s = sum_s;
          done_s   = 1'b1;
          busy_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          busy_s   = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      acc_r    <= {W{1'b0}};
      mcand_r  <= {W{1'b0}};
      mplier_r <= {MAXBITS{1'b0}};
      cnt_r    <= 6'd0;
      square   <= {W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      cnt_r    <= cnt_s;
      square   <= square_s;
      busy     <= busy_s;
      done     <= done_s;
    end
  end

endmodule
